spi_slave_param: RTL

- Parametrised SPI slave front end for the single-port RAM subsystem; replaces the fixed 10-bit, mode-0-only interface.
- Oversamples an external, asynchronous SPI bus (`sclk`, `ss_n`, `mosi`) on the system clock.
- Supports all four CPOL/CPHA modes and a configurable payload width.
- Carries an explicit 2-bit command in every frame (no hidden address/data toggle), returns read data on `miso` and flags truncated frames.

---
 rtl/spi_slave_param_if.sv | 26 ++
 rtl/spi_slave_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param_if.sv
// SPI pins plus the RAM-side receive/transmit signals of the SPI slave front end.
// tx_valid carries no ready: the slave samples tx_data only while it waits for read data.
interface spi_slave_param_if #(
    parameter int W = 8
);
    logic         sclk;
    logic         ss_n;
    logic         mosi;
    logic         miso;
    logic         miso_oe;
    logic [W+1:0] rx_data;
    logic         rx_valid;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         frame_err;

    modport slave (
        input  sclk, ss_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, rx_data, rx_valid, frame_err
    );

    modport master (
        output sclk, ss_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, rx_data, rx_valid, frame_err
    );
endinterface

// File: rtl/spi_slave_param.sv
// Oversampled SPI slave: {cmd[1:0], payload[W-1:0]} frames in, read data out on miso.
// Any CPOL/CPHA mode; truncated frames raise frame_err instead of rx_valid.
module spi_slave_param #(
    parameter int W    = 8,
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_slave_param_if.slave        bus,
    output logic [2:0]              dbg_state_o
);
    localparam int CW = $clog2(W + 3);
    localparam logic [CW-1:0] RX_LAST = CW'(W + 1);
    localparam logic [CW-1:0] TX_LAST = CW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECV    = 3'd1,
        S_WAIT_TX = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    logic [2:0]   sclk_q;
    logic [1:0]   ss_q;
    logic [1:0]   mosi_q;
    logic         armed_q;

    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W+1:0] rx_shift_q, rx_shift_d;
    logic [W-1:0] tx_shift_q, tx_shift_d;
    logic         miso_q, miso_d;
    logic [W+1:0] rx_data_q, rx_data_d;
    logic         rx_valid_q, rx_valid_d;
    logic         frame_err_q, frame_err_d;

    logic         ss_sync;
    logic         sclk_rise, sclk_fall;
    logic         sample_edge, shift_edge;
    logic [W+1:0] rx_shift_nxt;

    // ss_n synchroniser resets low so a select still held low after reset never arms
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q  <= {3{CPOL}};
            ss_q    <= '0;
            mosi_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            sclk_q  <= {sclk_q[1:0], bus.sclk};
            ss_q    <= {ss_q[0], bus.ss_n};
            mosi_q  <= {mosi_q[0], bus.mosi};
            if (ss_q[1]) armed_q <= 1'b1;
        end
    end

    assign ss_sync      = ss_q[1];
    assign sclk_rise    = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall    = ~sclk_q[1] & sclk_q[2];
    assign sample_edge  = (CPOL == CPHA) ? sclk_rise : sclk_fall;
    assign shift_edge   = (CPOL == CPHA) ? sclk_fall : sclk_rise;
    assign rx_shift_nxt = {rx_shift_q[W:0], mosi_q[1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        miso_d      = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        // Deselect overrides every state, including a tx_valid arriving in the same cycle
        if (ss_sync) begin
            state_d     = S_IDLE;
            frame_err_d = (state_q == S_RECV) || (state_q == S_WAIT_TX) ||
                          (state_q == S_SEND);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q) begin
                        cnt_d   = '0;
                        state_d = S_RECV;
                    end
                end
                S_RECV: begin
                    if (sample_edge) begin
                        rx_shift_d = rx_shift_nxt;
                        cnt_d      = cnt_q + CW'(1);
                        if (cnt_q == RX_LAST) begin
                            rx_data_d  = rx_shift_nxt;
                            rx_valid_d = 1'b1;
                            state_d    = (rx_shift_nxt[W+1:W] == 2'b11) ? S_WAIT_TX : S_DONE;
                        end
                    end
                end
                S_WAIT_TX: begin
                    if (bus.tx_valid) begin
                        cnt_d   = '0;
                        state_d = S_SEND;
                        // CPHA=0 must present the MSB before the first sample edge
                        if (CPHA) begin
                            tx_shift_d = bus.tx_data;
                        end else begin
                            miso_d     = bus.tx_data[W-1];
                            tx_shift_d = bus.tx_data << 1;
                        end
                    end
                end
                S_SEND: begin
                    miso_d = miso_q;
                    if (shift_edge) begin
                        miso_d     = tx_shift_q[W-1];
                        tx_shift_d = tx_shift_q << 1;
                    end
                    if (sample_edge) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == TX_LAST) begin
                            state_d = S_DONE;
                            miso_d  = 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.miso      = miso_q;
    assign bus.miso_oe   = (state_q == S_SEND) && !ss_sync;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign dbg_state_o   = state_q;
endmodule
